// File: rtl/dl_pkg.sv
// Shared types and ioctl index constants for the download sequencer.
package dl_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } dl_state_t;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

endpackage

// File: rtl/dl_sequencer_if.sv
// hps_io ioctl download bus: hps_io drives it (master), the sequencer consumes it (slave).
interface dl_sequencer_if;

    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    modport master (output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
    modport slave  (input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);

endinterface

// File: rtl/dl_rst_stretch.sv
// Loadable down-counter that stretches core reset for RST_HOLD cycles after a load ends.
module dl_rst_stretch #(
    parameter int RST_HOLD = 16
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic start,
    output logic done
);

    localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    logic [CW-1:0] cnt;
    logic          active;

    // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            cnt    <= CW'(RST_HOLD - 1);
            active <= 1'b1;
        end else if (cnt != '0) begin
            cnt    <= cnt - CW'(1);
        end
    end

    assign done = active && (cnt == '0);

endmodule

// File: rtl/dl_sequencer.sv
// ioctl download sequencer: routes ROM / variant / DIP downloads and holds the core in reset.
// Optional DL_CHKSUM_EN builds the additive ROM checksum; otherwise rom_sum is tied to zero.
module dl_sequencer
    import dl_pkg::*;
#(
    parameter int ROM_AW    = 16,
    parameter int DIP_BYTES = 8,
    parameter int RST_HOLD  = 16,
    parameter int ROM_MIN   = 16
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    dl_sequencer_if.slave          ioctl,
    output logic                   rom_wr,
    output logic [ROM_AW-1:0]      rom_addr,
    output logic [7:0]             rom_data,
    output logic [7:0]             mod_id,
    output logic [8*DIP_BYTES-1:0] sw,
    output logic                   core_reset,
    output logic                   busy,
    output logic                   dl_err,
    output logic [7:0]             rom_sum
);

    localparam logic [ROM_AW:0] CNT_MAX = {1'b1, {ROM_AW{1'b0}}};
    localparam logic [ROM_AW:0] MIN_CNT = (ROM_AW + 1)'(ROM_MIN);

    dl_state_t       state, state_nxt;
    logic            dl_prev, armed, load_rom;
    logic [ROM_AW:0] byte_cnt, cnt_base, cnt_inc;
    logic            rise, fall, dl_act, wr_ok, is_rom, is_mod, addr_ok;
    logic            rom_acc, rom_bad, reload, enter_load, short_load, settle_start, settle_done;

    // After a reset, writes and load requests are ignored until a fresh rising edge of download.
    assign rise    = ioctl.ioctl_download & ~dl_prev;
    assign fall    = dl_prev & ~ioctl.ioctl_download;
    assign dl_act  = ioctl.ioctl_download & (armed | rise);
    assign wr_ok   = ioctl.ioctl_wr & (armed | rise);
    assign is_rom  = (ioctl.ioctl_index == IDX_ROM);
    assign is_mod  = (ioctl.ioctl_index == IDX_MOD);
    assign addr_ok = ((ioctl.ioctl_addr >> ROM_AW) == '0);
    assign rom_acc = wr_ok & is_rom & addr_ok;
    assign rom_bad = wr_ok & is_rom & ~addr_ok;
    assign reload  = dl_act & (is_rom | is_mod);

    assign enter_load = (state == BOOT) ? (dl_act & is_rom) : ((state != LOAD) & reload);

    // The byte landing with the entry edge counts toward the fresh load; the count saturates.
    assign cnt_base = (enter_load && is_rom) ? '0 : byte_cnt;
    assign cnt_inc  = (rom_acc && cnt_base != CNT_MAX) ? cnt_base + 1'b1 : cnt_base;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        short_load   = 1'b0;
        settle_start = 1'b0;
        case (state)
            BOOT:   if (enter_load) state_nxt = LOAD;
            LOAD: begin
                if (fall) begin
                    if (load_rom && cnt_inc < MIN_CNT) begin
                        short_load = 1'b1;
                        state_nxt  = BOOT;
                    end else begin
                        settle_start = 1'b1;
                        state_nxt    = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (reload)           state_nxt = LOAD;
                else if (settle_done) state_nxt = RUN;
            end
            RUN:    if (reload) state_nxt = LOAD;
            default: state_nxt = BOOT;
        endcase
    end

    dl_rst_stretch #(.RST_HOLD(RST_HOLD)) u_stretch (
        .clk_sys (clk_sys),
        .reset   (reset),
        .start   (settle_start),
        .done    (settle_done)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= BOOT;
            dl_prev  <= 1'b1;
            armed    <= 1'b0;
            load_rom <= 1'b0;
            byte_cnt <= '0;
            rom_wr   <= 1'b0;
            rom_addr <= '0;
            rom_data <= '0;
            mod_id   <= '0;
            sw       <= '1;
            dl_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            dl_prev  <= ioctl.ioctl_download;
            byte_cnt <= cnt_inc;
            rom_wr   <= rom_acc;
            if (rise)       armed    <= 1'b1;
            if (enter_load) load_rom <= is_rom;
            if (rom_acc) begin
                rom_addr <= ioctl.ioctl_addr[ROM_AW-1:0];
                rom_data <= ioctl.ioctl_dout;
            end
            if (wr_ok && is_mod) mod_id <= ioctl.ioctl_dout;
            if (wr_ok && ioctl.ioctl_index == IDX_DIP) begin
                for (int k = 0; k < DIP_BYTES; k++) begin
                    if (ioctl.ioctl_addr == 25'(k)) sw[8*k +: 8] <= ioctl.ioctl_dout;
                end
            end
            // A fault in the same cycle as the clear must still be recorded.
            if (enter_load && state == BOOT) dl_err <= 1'b0;
            if (rom_bad || short_load)       dl_err <= 1'b1;
        end
    end

`ifdef DL_CHKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sum_q <= '0;
        end else if (enter_load && is_rom) begin
            sum_q <= rom_acc ? ioctl.ioctl_dout : 8'h00;
        end else if (rom_acc && state == LOAD) begin
            sum_q <= sum_q + ioctl.ioctl_dout;
        end
    end

    assign rom_sum = sum_q;
`else
    assign rom_sum = 8'h00;
`endif

    assign core_reset = (state != RUN);
    assign busy       = (state != RUN);

endmodule

// File: tb/tb_dl_sequencer.sv
// Randomised scoreboard bench for dl_sequencer against a byte-level reference model.
module tb_dl_sequencer;
    import dl_pkg::*;

    localparam int ROM_AW    = 16;
    localparam int DIP_BYTES = 8;
    localparam int RST_HOLD  = 16;
    localparam int ROM_MIN   = 16;

    logic                   clk_sys = 1'b0;
    logic                   reset;
    logic                   rom_wr;
    logic [ROM_AW-1:0]      rom_addr;
    logic [7:0]             rom_data;
    logic [7:0]             mod_id;
    logic [8*DIP_BYTES-1:0] sw;
    logic                   core_reset;
    logic                   busy;
    logic                   dl_err;
    logic [7:0]             rom_sum;

    dl_sequencer_if ioctl ();

    dl_sequencer #(
        .ROM_AW(ROM_AW), .DIP_BYTES(DIP_BYTES), .RST_HOLD(RST_HOLD), .ROM_MIN(ROM_MIN)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ioctl      (ioctl),
        .rom_wr     (rom_wr),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .mod_id     (mod_id),
        .sw         (sw),
        .core_reset (core_reset),
        .busy       (busy),
        .dl_err     (dl_err),
        .rom_sum    (rom_sum)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        logic [ROM_AW-1:0] addr;
        logic [7:0]        data;
        int unsigned       when;
    } rom_exp_t;

    rom_exp_t rom_q[$];
    rom_exp_t mon_e;

    // Reference model: what software expects to see after each download.
    logic [7:0] m_sw [DIP_BYTES];
    logic [7:0] m_mod;
    logic       m_err;
    logic [7:0] m_sum;
    logic       m_boot;
    int         m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every ROM strobe must match the oldest outstanding accepted byte.
    always @(negedge clk_sys) begin
        if (rom_wr === 1'b1) begin
            if (rom_q.size() == 0) begin
                check("rom_wr_unexpected", rom_wr, 1'b0);
            end else begin
                mon_e = rom_q.pop_front();
                check("rom_addr", rom_addr, mon_e.addr);
                check("rom_data", rom_data, mon_e.data);
                check("rom_wr_latency", cyc, mon_e.when);
            end
        end
    end

    function automatic logic [63:0] model_sw();
        logic [63:0] v = '0;
        for (int k = 0; k < DIP_BYTES; k++) v[8*k +: 8] = m_sw[k];
        return v;
    endfunction

    function automatic logic [7:0] exp_sum();
`ifdef DL_CHKSUM_EN
        return m_sum;
`else
        return 8'h00;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DIP_BYTES; k++) m_sw[k] = 8'hFF;
        m_mod  = 8'h00;
        m_err  = 1'b0;
        m_sum  = 8'h00;
        m_boot = 1'b1;
        m_cnt  = 0;
        rom_q.delete();
    endtask

    task automatic model_write(input logic [24:0] a, input logic [7:0] d);
        rom_exp_t e;
        case (ioctl.ioctl_index)
            IDX_ROM: begin
                if (a < 25'(1 << ROM_AW)) begin
                    e.addr = a[ROM_AW-1:0];
                    e.data = d;
                    e.when = cyc + 1;
                    rom_q.push_back(e);
                    m_sum = m_sum + d;
                    m_cnt++;
                end else begin
                    m_err = 1'b1;
                end
            end
            IDX_MOD: m_mod = d;
            IDX_DIP: if (a < 25'(DIP_BYTES)) m_sw[a] = d;
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_mod_id"}, mod_id, m_mod);
        check({tag, "_sw"}, sw, model_sw());
        check({tag, "_dl_err"}, dl_err, m_err);
        check({tag, "_rom_sum"}, rom_sum, exp_sum());
        check({tag, "_core_reset"}, core_reset, m_boot);
        check({tag, "_busy"}, busy, m_boot);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        @(negedge clk_sys);
        ioctl.ioctl_index    = idx;
        ioctl.ioctl_download = 1'b1;
        ioctl.ioctl_wr       = 1'b0;
        if (idx == IDX_ROM || idx == IDX_MOD) begin
            if (idx == IDX_ROM) begin
                if (m_boot) m_err = 1'b0;
                m_sum = 8'h00;
                m_cnt = 0;
            end
            @(negedge clk_sys);
            check("core_reset_in_load", core_reset, 1'b1);
        end
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit live);
        @(negedge clk_sys);
        ioctl.ioctl_wr   = 1'b1;
        ioctl.ioctl_addr = a;
        ioctl.ioctl_dout = d;
        if (live) model_write(a, d);
        @(negedge clk_sys);
        ioctl.ioctl_wr = 1'b0;
    endtask

    // Drops download (optionally with a byte in that same cycle) and times the core reset release.
    task automatic finish_load(input bit with_byte, input logic [24:0] a, input logic [7:0] d);
        int  n = 0;
        bit  exp_run;
        @(negedge clk_sys);
        ioctl.ioctl_download = 1'b0;
        if (with_byte) begin
            ioctl.ioctl_wr   = 1'b1;
            ioctl.ioctl_addr = a;
            ioctl.ioctl_dout = d;
            model_write(a, d);
        end
        exp_run = !(ioctl.ioctl_index == IDX_ROM && m_cnt < ROM_MIN);
        if (!exp_run) begin
            m_err  = 1'b1;
            m_boot = 1'b1;
        end
        for (int k = 0; k < RST_HOLD + 20; k++) begin
            @(negedge clk_sys);
            ioctl.ioctl_wr = 1'b0;
            if (core_reset !== 1'b1) break;
            n++;
        end
        if (exp_run) begin
            check("release_delay", n, RST_HOLD);
            m_boot = 1'b0;
        end else begin
            check("held_in_boot", n, RST_HOLD + 20);
        end
    endtask

    initial begin
        logic [7:0] t1_sum;
        int         len;
        int         bad_at;

        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1_sum;
        int         len;
        int         bad_at;
`ifdef DL_CHKSUM_EN
        t1_sum = 8'hF0;
`else
        t1_sum = 8'h00;
`endif
        reset                = 1'b1;
        ioctl.ioctl_download = 1'b0;
        ioctl.ioctl_wr       = 1'b0;
        ioctl.ioctl_index    = 8'h00;
        ioctl.ioctl_addr     = '0;
        ioctl.ioctl_dout     = 8'h00;
        model_reset();
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);

        check("reset_rom_wr", rom_wr, 1'b0);
        check("reset_rom_addr", rom_addr, '0);
        check("reset_rom_data", rom_data, 8'h00);
        check_outputs("reset");

        // 32-byte ROM load with dout = addr
        start_dl(IDX_ROM);
        for (int a = 0; a < 32; a++) wr_byte(25'(a), 8'(a), 1'b1);
        finish_load(1'b0, '0, 8'h00);
        check("t1_rom_sum", rom_sum, t1_sum);
        check_outputs("t1");

        // Short ROM load falls back to BOOT with an error
        start_dl(IDX_ROM);
        for (int a = 0; a < 8; a++) wr_byte(25'(a), 8'($urandom), 1'b1);
        finish_load(1'b0, '0, 8'h00);
        check_outputs("t2");

        // Exactly ROM_MIN bytes, the last landing with the download falling edge
        start_dl(IDX_ROM);
        for (int a = 0; a < ROM_MIN - 1; a++) wr_byte(25'(a), 8'($urandom), 1'b1);
        finish_load(1'b1, 25'(ROM_MIN - 1), 8'($urandom));
        check_outputs("edge_byte");

        // Live DIP update in RUN
        start_dl(IDX_DIP);
        for (int a = 0; a < 10; a++) begin
            wr_byte(25'(a), 8'hA0 + 8'(a), 1'b1);
            check("dip_core_reset", core_reset, 1'b0);
        end
        @(negedge clk_sys);
        ioctl.ioctl_download = 1'b0;
        @(negedge clk_sys);
        check_outputs("t3");
        start_dl(IDX_DIP);
        for (int i = 0; i < 12; i++) wr_byte(25'($urandom_range(0, 11)), 8'($urandom), 1'b1);
        @(negedge clk_sys);
        ioctl.ioctl_download = 1'b0;
        @(negedge clk_sys);
        check_outputs("dip_rand");

        // Variant id: last byte wins
        start_dl(IDX_MOD);
        wr_byte(25'd0, 8'd3, 1'b1);
        wr_byte(25'd1, 8'd5, 1'b1);
        finish_load(1'b0, '0, 8'h00);
        check("t5_mod_id", mod_id, 8'd5);
        check_outputs("t5");

        // ROM load in RUN with one out-of-range write and the top in-range address
        len    = $urandom_range(ROM_MIN, 40);
        bad_at = $urandom_range(0, len - 1);
        start_dl(IDX_ROM);
        for (int a = 0; a < len; a++) begin
            if (a == bad_at) wr_byte(25'h10000, 8'($urandom), 1'b1);
            wr_byte(25'(a), 8'($urandom), 1'b1);
        end
        wr_byte(25'h0FFFF, 8'($urandom), 1'b1);
        finish_load(1'b0, '0, 8'h00);
        check_outputs("t4");

        // Reset in the middle of a ROM load
        start_dl(IDX_ROM);
        for (int a = 0; a < 5; a++) wr_byte(25'(a), 8'($urandom), 1'b1);
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        model_reset();
        check("t6_core_reset", core_reset, 1'b1);
        check("t6_rom_wr", rom_wr, 1'b0);
        check_outputs("t6");
        for (int a = 5; a < 20; a++) wr_byte(25'(a), 8'($urandom), 1'b0);
        @(negedge clk_sys);
        ioctl.ioctl_download = 1'b0;
        repeat (RST_HOLD + 4) @(negedge clk_sys);
        check_outputs("t6_after");

        // Fresh random load after the reset
        len = $urandom_range(ROM_MIN, 48);
        start_dl(IDX_ROM);
        for (int a = 0; a < len; a++) wr_byte(25'(a), 8'($urandom), 1'b1);
        finish_load(1'b0, '0, 8'h00);
        check_outputs("final");

        repeat (3) @(negedge clk_sys);
        check("rom_queue_drained", rom_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
